fetch_sequencer: RTL and testbench

Instruction fetch and cycle sequencer that sits directly upstream of the `control` decoder. It fetches one 8-bit instruction per instruction slot over a req/ack memory port and holds it in the instruction register (IR) that drives `control.inst`. It generates the `cycle` phase bit for two-cycle instructions (`inst[7]=1`), and owns the program counter and the carry flag that feed `control.cycle` and `control.carry`. It consumes `J`, `LJ` and `WC` back from `control` to redirect the PC and update carry.

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 68 ++++++
 tb/tb_fetch_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer ports: memory req/ack fetch port plus the control-decoder side.
// The sequencer side uses the master modport, and memory/control/datapath use the slave modport.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              stall;
  logic              J;
  logic              LJ;
  logic              WC;
  logic              alu_carry;
  logic [ADDR_W-1:0] jump_target;
  logic [7:0]        inst;
  logic              cycle;
  logic              carry;
  logic              inst_valid;

  modport master (
    output mem_req, mem_addr, inst, cycle, carry, inst_valid,
    input  mem_ack, mem_rdata, stall, J, LJ, WC, alu_carry, jump_target
  );

  modport slave (
    input  mem_req, mem_addr, inst, cycle, carry, inst_valid,
    output mem_ack, mem_rdata, stall, J, LJ, WC, alu_carry, jump_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch and cycle sequencer: IR, PC, carry and the cycle phase for the control decoder.
// Latency: 2 clocks per instruction, or 3 when IR[7]=1. mem_ack waits and stall cycles each add 1 clock.
module fetch_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_sequencer_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC0 = 2'd2;
  localparam logic [1:0] EXEC1 = 2'd3;
  localparam logic [ADDR_W-1:0] pcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic              carryQ;
  logic              execState;
  logic              exitCycle;

  assign execState = (state == EXEC0) || (state == EXEC1);
  // J/LJ/WC only matter on the edge that actually leaves an execute phase.
  assign exitCycle = execState && !bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= 8'h00;
      carryQ <= 1'b0;
    end else begin
      if (exitCycle && bus.WC) carryQ <= bus.alu_carry;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.mem_ack) begin
            ir    <= bus.mem_rdata;
            pc    <= pc + pcOne;
            state <= EXEC0;
          end
        end
        EXEC0: begin
          if (!bus.stall) begin
            state <= ir[7] ? EXEC1 : FETCH;
            if (bus.LJ) pc <= bus.jump_target;
          end
        end
        EXEC1: begin
          if (!bus.stall) begin
            state <= FETCH;
            if (bus.J) pc <= bus.jump_target;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = (state == FETCH);
  assign bus.mem_addr   = pc;
  assign bus.inst       = ir;
  assign bus.cycle      = (state == EXEC1);
  assign bus.inst_valid = execState;
  assign bus.carry      = carryQ;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against an instruction-level model of PC and carry.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mPc;
  logic        mCarry;

  fetch_sequencer_if #(.ADDR_W(16)) bus ();

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_req"},   32'(bus.mem_req), 32'h0);
    check({tag, "_addr"},  32'(bus.mem_addr), 32'h0);
    check({tag, "_inst"},  32'(bus.inst), 32'h0);
    check({tag, "_cycle"}, 32'(bus.cycle), 32'h0);
    check({tag, "_valid"}, 32'(bus.inst_valid), 32'h0);
    check({tag, "_carry"}, 32'(bus.carry), 32'h0);
  endtask

  // Junk on the control inputs while stalled: every flag set, carry inverted.
  task automatic driveStallJunk();
    bus.stall       = 1'b1;
    bus.J           = 1'b1;
    bus.LJ          = 1'b1;
    bus.WC          = 1'b1;
    bus.alu_carry   = ~mCarry;
    bus.jump_target = 16'($urandom);
    bus.mem_ack     = 1'($urandom);
    bus.mem_rdata   = 8'($urandom);
  endtask

  task automatic fetchPhase(input logic [7:0] op, input int waits);
    check("fetch_req",   32'(bus.mem_req), 32'h1);
    check("fetch_addr",  32'(bus.mem_addr), 32'(mPc));
    check("fetch_valid", 32'(bus.inst_valid), 32'h0);
    check("fetch_cycle", 32'(bus.cycle), 32'h0);
    for (int w = 0; w < waits; w++) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'($urandom);
      bus.stall     = 1'($urandom);
      bus.WC        = 1'($urandom);
      bus.alu_carry = 1'($urandom);
      tick();
      check("wait_req",   32'(bus.mem_req), 32'h1);
      check("wait_addr",  32'(bus.mem_addr), 32'(mPc));
      check("wait_carry", 32'(bus.carry), 32'(mCarry));
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = op;
    tick();
    mPc = mPc + 16'd1;
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = 8'($urandom);
  endtask

  task automatic execPhase(input logic [7:0] op, input bit phase1, input int stalls,
                           input bit jmp, input logic [15:0] tgt, input bit wc, input bit c);
    check(phase1 ? "e1_inst" : "e0_inst",   32'(bus.inst), 32'(op));
    check(phase1 ? "e1_cycle" : "e0_cycle", 32'(bus.cycle), 32'(phase1));
    check(phase1 ? "e1_valid" : "e0_valid", 32'(bus.inst_valid), 32'h1);
    check(phase1 ? "e1_req" : "e0_req",     32'(bus.mem_req), 32'h0);
    for (int s = 0; s < stalls; s++) begin
      driveStallJunk();
      tick();
      check("stall_inst",  32'(bus.inst), 32'(op));
      check("stall_cycle", 32'(bus.cycle), 32'(phase1));
      check("stall_valid", 32'(bus.inst_valid), 32'h1);
      check("stall_carry", 32'(bus.carry), 32'(mCarry));
    end
    bus.stall       = 1'b0;
    bus.J           = phase1 ? jmp : 1'($urandom);
    bus.LJ          = phase1 ? 1'($urandom) : jmp;
    bus.WC          = wc;
    bus.alu_carry   = c;
    bus.jump_target = tgt;
    tick();
    if (jmp) mPc = tgt;
    if (wc) mCarry = c;
    check("exit_carry", 32'(bus.carry), 32'(mCarry));
    bus.J  = 1'b0;
    bus.LJ = 1'b0;
    bus.WC = 1'b0;
  endtask

  task automatic runInstr(input logic [7:0] op, input int waits, input int s0, input int s1,
                          input bit lj0, input logic [15:0] t0, input bit wc0, input bit c0,
                          input bit j1, input logic [15:0] t1, input bit wc1, input bit c1);
    fetchPhase(op, waits);
    execPhase(op, 1'b0, s0, lj0, t0, wc0, c0);
    if (op[7]) execPhase(op, 1'b1, s1, j1, t1, wc1, c1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.stall = 1'b0;
    bus.J = 1'b0; bus.LJ = 1'b0; bus.WC = 1'b0; bus.alu_carry = 1'b0;
    bus.jump_target = 16'h0000;
    mPc = 16'h0000;
    mCarry = 1'b0;
    #1;
    checkReset("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_req", 32'(bus.mem_req), 32'h0);
    tick();

    // Linear fetch, zero-wait memory.
    runInstr(8'h40, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
    runInstr(8'h41, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
    // Two-cycle jump taken, then not taken.
    runInstr(8'hE0, 0, 0, 0, 0, 16'h0, 0, 0, 1, 16'h1234, 0, 0);
    runInstr(8'hE0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h5555, 0, 0);
    // LJ in EXEC0 goes straight to FETCH.
    runInstr(8'h10, 0, 0, 0, 1, 16'h00FF, 0, 0, 0, 16'h0, 0, 0);
    // Carry write held off by three stall cycles.
    runInstr(8'h01, 0, 3, 0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 0);
    // Wait states and PC wrap.
    runInstr(8'h02, 0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 16'h0, 0, 0);
    runInstr(8'h03, 2, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
    check("wrap_addr", 32'(bus.mem_addr), 32'h0000);

    // Reset during EXEC1 abandons the instruction.
    fetchPhase(8'hE0, 1);
    execPhase(8'hE0, 1'b0, 0, 0, 16'h0, 0, 0);
    check("pre_rst_cycle", 32'(bus.cycle), 32'h1);
    bus.J = 1'b1; bus.WC = 1'b1; bus.alu_carry = 1'b0; bus.jump_target = 16'hBEEF;
    #2 rst_n = 1'b0;
    #1;
    checkReset("midrst");
    mPc = 16'h0000;
    mCarry = 1'b0;
    bus.J = 1'b0; bus.WC = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("idle2_req", 32'(bus.mem_req), 32'h0);
    tick();
    runInstr(8'h44, 0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      runInstr(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 1'($urandom), 16'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    check("final_req",  32'(bus.mem_req), 32'h1);
    check("final_addr", 32'(bus.mem_addr), 32'(mPc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
